// File: rtl/rsnn_sequencer.sv
// rsnn_sequencer: controller between the chip pin wrapper and the RSNN core.
//   Config phase: accepts parameter bytes (param_valid/param_ready), shifts each one MSB first
//   into the core's serial port (rsnn_data_in with rsnn_load_params high), then waits for the
//   core's byte acknowledge. A missing ack within ACK_TIMEOUT cycles raises a sticky error.
//   Inference phase: for each of num_steps timesteps, latches ext_spikes into the core input
//   register, enables the core for STEP_CYCLES cycles, then adds the core output spikes into
//   per-output saturating 8-bit counters.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cfg_start, run_start            start pulses (honoured in IDLE; ERROR accepts cfg_start)
//   num_steps                       timesteps per run, sampled on an accepted run_start
//   param_byte/valid/ready          upstream parameter byte stream
//   ext_spikes                      external input spikes
//   rsnn_*                          core-facing strobes, serial data and handshakes
//   spike_count                     output i count at bits [8i+7:8i]
//   busy, loaded, done, error       status
module rsnn_sequencer #(
  parameter int unsigned NUM_INPUTS  = 3,
  parameter int unsigned NUM_OUTPUTS = 3,
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic                     run_start,
  input  logic [7:0]               num_steps,
  input  logic [7:0]               param_byte,
  input  logic                     param_valid,
  output logic                     param_ready,
  input  logic [NUM_INPUTS-1:0]    ext_spikes,
  output logic [NUM_INPUTS-1:0]    rsnn_input_spikes,
  output logic                     rsnn_spike_reg_en,
  output logic                     rsnn_enable,
  output logic                     rsnn_data_in,
  output logic                     rsnn_load_params,
  input  logic [NUM_OUTPUTS-1:0]   rsnn_output_spikes,
  input  logic                     rsnn_data_written,
  input  logic                     rsnn_end_writing,
  output logic [8*NUM_OUTPUTS-1:0] spike_count,
  output logic                     busy,
  output logic                     loaded,
  output logic                     done,
  output logic                     error
);

  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] TimeoutLast = TW'(ACK_TIMEOUT - 1);
  localparam logic [SW-1:0] StepLast    = SW'(STEP_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StLdWait, StLdShift, StLdAck, StLatch, StStep, StCapture, StDone, StError
  } state_e;

  state_e                   state_q, state_d;
  logic [7:0]               byte_q, byte_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic                     ack_q, ack_d;
  logic [TW-1:0]            timeout_q, timeout_d;
  logic [SW-1:0]            step_cyc_q, step_cyc_d;
  logic [7:0]               step_cnt_q, step_cnt_d;
  logic [7:0]               num_steps_q, num_steps_d;
  logic [8*NUM_OUTPUTS-1:0] counts_q, counts_d;
  logic                     loaded_q, loaded_d;
  logic                     error_q, error_d;
  logic [NUM_INPUTS-1:0]    spikes_q, spikes_d;
  logic                     in_load;

  assign in_load = (state_q == StLdWait) || (state_q == StLdShift) || (state_q == StLdAck);

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    bit_cnt_d   = bit_cnt_q;
    ack_d       = ack_q;
    timeout_d   = timeout_q;
    step_cyc_d  = step_cyc_q;
    step_cnt_d  = step_cnt_q;
    num_steps_d = num_steps_q;
    counts_d    = counts_q;
    loaded_d    = loaded_q;
    error_d     = error_q;
    spikes_d    = spikes_q;

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d  = StLdWait;
          loaded_d = 1'b0;
          error_d  = 1'b0;
        end else if (run_start && loaded_q) begin
          counts_d    = '0;
          step_cnt_d  = '0;
          num_steps_d = num_steps;
          state_d     = (num_steps == 8'd0) ? StDone : StLatch;
        end
      end
      StError: begin
        if (cfg_start) begin
          state_d  = StLdWait;
          loaded_d = 1'b0;
          error_d  = 1'b0;
        end
      end
      StLdWait: begin
        if (param_valid) begin
          byte_d    = param_byte;
          bit_cnt_d = '0;
          ack_d     = 1'b0;
          state_d   = StLdShift;
        end
      end
      StLdShift: begin
        byte_d    = {byte_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (rsnn_data_written) ack_d = 1'b1;
        if (bit_cnt_q == 3'd7) begin
          state_d   = StLdAck;
          timeout_d = '0;
        end
      end
      StLdAck: begin
        // An ack arriving in this very cycle counts as well as one latched earlier.
        if (ack_q || rsnn_data_written) begin
          ack_d   = 1'b1;
          state_d = StLdWait;
        end else if (timeout_q == TimeoutLast) begin
          state_d  = StError;
          error_d  = 1'b1;
          loaded_d = 1'b0;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      StLatch: begin
        step_cyc_d = '0;
        state_d    = StStep;
      end
      StStep: begin
        if (step_cyc_q == StepLast) state_d = StCapture;
        else step_cyc_d = step_cyc_q + 1'b1;
      end
      StCapture: begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
          if (rsnn_output_spikes[i] && (counts_q[8*i +: 8] != 8'hFF)) begin
            counts_d[8*i +: 8] = counts_q[8*i +: 8] + 8'd1;
          end
        end
        step_cnt_d = step_cnt_q + 8'd1;
        state_d    = (step_cnt_d == num_steps_q) ? StDone : StLatch;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // End of parameter stream overrides ack/timeout handling; any byte in flight is dropped.
    if (in_load && rsnn_end_writing) begin
      state_d  = StIdle;
      loaded_d = 1'b1;
      error_d  = 1'b0;
    end

    if (state_d == StLatch) spikes_d = ext_spikes;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      byte_q      <= '0;
      bit_cnt_q   <= '0;
      ack_q       <= 1'b0;
      timeout_q   <= '0;
      step_cyc_q  <= '0;
      step_cnt_q  <= '0;
      num_steps_q <= '0;
      counts_q    <= '0;
      loaded_q    <= 1'b0;
      error_q     <= 1'b0;
      spikes_q    <= '0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      bit_cnt_q   <= bit_cnt_d;
      ack_q       <= ack_d;
      timeout_q   <= timeout_d;
      step_cyc_q  <= step_cyc_d;
      step_cnt_q  <= step_cnt_d;
      num_steps_q <= num_steps_d;
      counts_q    <= counts_d;
      loaded_q    <= loaded_d;
      error_q     <= error_d;
      spikes_q    <= spikes_d;
    end
  end

  assign param_ready       = (state_q == StLdWait);
  assign rsnn_load_params  = in_load;
  assign rsnn_data_in      = (state_q == StLdShift) ? byte_q[7] : 1'b0;
  assign rsnn_spike_reg_en = (state_q == StLatch);
  assign rsnn_enable       = (state_q == StStep);
  assign rsnn_input_spikes = spikes_q;
  assign spike_count       = counts_q;
  assign busy              = (state_q != StIdle) && (state_q != StError);
  assign loaded            = loaded_q;
  assign done              = (state_q == StDone);
  assign error             = error_q;

endmodule

// File: tb/tb_rsnn_sequencer.sv
module tb_rsnn_sequencer;

  localparam int unsigned NI = 3;
  localparam int unsigned NO = 3;
  localparam int unsigned SC = 4;
  localparam int unsigned AT = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          run_start = 1'b0;
  logic [7:0]    num_steps = '0;
  logic [7:0]    param_byte = '0;
  logic          param_valid = 1'b0;
  logic          param_ready;
  logic [NI-1:0] ext_spikes = '0;
  logic [NI-1:0] rsnn_input_spikes;
  logic          rsnn_spike_reg_en;
  logic          rsnn_enable;
  logic          rsnn_data_in;
  logic          rsnn_load_params;
  logic [NO-1:0] rsnn_output_spikes = '0;
  logic          rsnn_data_written = 1'b0;
  logic          rsnn_end_writing = 1'b0;
  logic [8*NO-1:0] spike_count;
  logic          busy, loaded, done, error;

  int errors = 0;
  int checks = 0;

  rsnn_sequencer #(
    .NUM_INPUTS (NI),
    .NUM_OUTPUTS(NO),
    .STEP_CYCLES(SC),
    .ACK_TIMEOUT(AT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_start         (cfg_start),
    .run_start         (run_start),
    .num_steps         (num_steps),
    .param_byte        (param_byte),
    .param_valid       (param_valid),
    .param_ready       (param_ready),
    .ext_spikes        (ext_spikes),
    .rsnn_input_spikes (rsnn_input_spikes),
    .rsnn_spike_reg_en (rsnn_spike_reg_en),
    .rsnn_enable       (rsnn_enable),
    .rsnn_data_in      (rsnn_data_in),
    .rsnn_load_params  (rsnn_load_params),
    .rsnn_output_spikes(rsnn_output_spikes),
    .rsnn_data_written (rsnn_data_written),
    .rsnn_end_writing  (rsnn_end_writing),
    .spike_count       (spike_count),
    .busy              (busy),
    .loaded            (loaded),
    .done              (done),
    .error             (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ns;
    logic [2:0] ext;
    logic [2:0] outs;
    logic [23:0] cnt;
  } run_vec_t;

  run_vec_t   runs [4];
  logic [7:0] bytes [2];
  logic [2:0] last_latched = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {28'd0, rsnn_input_spikes, rsnn_spike_reg_en, rsnn_enable, rsnn_data_in,
            rsnn_load_params, spike_count, busy, loaded, done, error, param_ready};
  endfunction

  // One IDLE->LD_WAIT->...->IDLE load of the byte table, acks 2 cycles after each shift.
  task automatic load_table();
    logic [7:0] got;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("ld_wait_ready", {63'd0, param_ready}, 64'd1);
    for (int b = 0; b < 2; b++) begin
      param_byte = bytes[b]; param_valid = 1'b1; tick(); param_valid = 1'b0;
      got = '0;
      for (int k = 0; k < 8; k++) begin
        got = {got[6:0], rsnn_data_in};
        tick();
      end
      chk($sformatf("shift_byte%0d", b), {56'd0, got}, {56'd0, bytes[b]});
      chk("ld_ack_mode", {62'd0, rsnn_load_params, param_ready}, 64'd2);
      chk("ld_ack_data0", {63'd0, rsnn_data_in}, 64'd0);
      tick(); rsnn_data_written = 1'b1; tick(); rsnn_data_written = 1'b0;
      chk("ack_back_wait", {63'd0, param_ready}, 64'd1);
    end
    rsnn_end_writing = 1'b1; tick(); rsnn_end_writing = 1'b0;
    chk("load_end", {60'd0, loaded, busy, param_ready, rsnn_load_params}, 64'h8);
  endtask

  task automatic do_run(input run_vec_t v);
    int lat;
    int latches;
    int ens;
    logic [2:0] exp_in;
    ext_spikes = v.ext; rsnn_output_spikes = v.outs; num_steps = v.ns[7:0];
    run_start = 1'b1; tick(); run_start = 1'b0;
    lat = -1; latches = 0; ens = 0;
    for (int k = 0; k < 4000; k++) begin
      latches += int'(rsnn_spike_reg_en);
      ens += int'(rsnn_enable);
      if (done) begin lat = k; break; end
      tick();
    end
    exp_in = (v.ns > 0) ? v.ext : last_latched;
    last_latched = exp_in;
    chk($sformatf("latency_ns%0d", v.ns), 64'(lat), 64'(v.ns * (SC + 2)));
    chk($sformatf("latches_ns%0d", v.ns), 64'(latches), 64'(v.ns));
    chk($sformatf("enables_ns%0d", v.ns), 64'(ens), 64'(v.ns * SC));
    chk($sformatf("counts_ns%0d", v.ns), {40'd0, spike_count}, {40'd0, v.cnt});
    chk($sformatf("in_spikes_ns%0d", v.ns), {61'd0, rsnn_input_spikes}, {61'd0, exp_in});
    tick();
    chk("done_one_cycle", {62'd0, done, busy}, 64'd0);
    chk("counts_held", {40'd0, spike_count}, {40'd0, v.cnt});
  endtask

  initial begin
    bytes[0] = 8'hA5;
    bytes[1] = 8'h3C;
    runs[0] = '{ns: 5,   ext: 3'b101, outs: 3'b011, cnt: 24'h000505};
    runs[1] = '{ns: 3,   ext: 3'b010, outs: 3'b110, cnt: 24'h030300};
    runs[2] = '{ns: 0,   ext: 3'b111, outs: 3'b111, cnt: 24'h000000};
    runs[3] = '{ns: 255, ext: 3'b011, outs: 3'b001, cnt: 24'h0000FF};

    // Reset values
    #1;
    chk("reset_outs", all_outs(), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_outs", all_outs(), 64'd0);

    // run_start while not loaded is ignored
    num_steps = 8'd2; run_start = 1'b1; tick(); run_start = 1'b0;
    chk("run_unloaded", {61'd0, busy, rsnn_spike_reg_en, done}, 64'd0);
    tick();
    chk("run_unloaded2", {61'd0, busy, rsnn_spike_reg_en, rsnn_enable}, 64'd0);

    // Reset in the middle of LD_SHIFT
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    param_byte = 8'hFF; param_valid = 1'b1; tick(); param_valid = 1'b0;
    tick(); tick();
    chk("mid_shift_active", {62'd0, rsnn_load_params, rsnn_data_in}, 64'd3);
    rst_n = 1'b0; #1;
    chk("async_reset", all_outs(), 64'd0);
    tick(); rst_n = 1'b1; tick();
    chk("after_mid_reset", all_outs(), 64'd0);

    // Load two bytes
    load_table();

    // Inference runs
    foreach (runs[i]) do_run(runs[i]);

    // Ack timeout
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("cfg_keeps_counts", {40'd0, spike_count}, {40'd0, runs[3].cnt});
    chk("cfg_clears_loaded", {63'd0, loaded}, 64'd0);
    param_byte = 8'h5A; param_valid = 1'b1; tick(); param_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    for (int k = 0; k < AT - 1; k++) tick();
    chk("no_error_before_timeout", {63'd0, error}, 64'd0);
    tick();
    chk("timeout_error", {61'd0, error, loaded, busy}, 64'h4);
    num_steps = 8'd3; run_start = 1'b1; tick(); run_start = 1'b0;
    chk("error_ignores_run", {60'd0, error, busy, rsnn_spike_reg_en, param_ready}, 64'h8);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("cfg_clears_error", {61'd0, error, param_ready, rsnn_load_params}, 64'h3);
    rsnn_end_writing = 1'b1; tick(); rsnn_end_writing = 1'b0;
    chk("reloaded", {62'd0, loaded, param_ready}, 64'h2);

    // cfg_start and run_start together: load wins
    num_steps = 8'd4; cfg_start = 1'b1; run_start = 1'b1; tick();
    cfg_start = 1'b0; run_start = 1'b0;
    chk("cfg_wins", {60'd0, rsnn_load_params, param_ready, rsnn_spike_reg_en, loaded}, 64'hC);
    tick();
    chk("cfg_wins_no_run", {62'd0, rsnn_enable, rsnn_spike_reg_en}, 64'd0);
    chk("cfg_wins_counts", {40'd0, spike_count}, {40'd0, runs[3].cnt});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
